// File: rtl/rob_tag_alloc_if.sv
// rob_tag_alloc_if: allocation/retire/flush bus between the instruction buffer and the ROB tag allocator.
interface rob_tag_alloc_if #(parameter int TAG_W = 4);
    logic [2:0]                  alloc_req;
    logic [2:0]                  alloc_grant;
    logic [0:3][TAG_W-1:0]       alloc_tag;
    logic [2:0]                  retire_cnt;
    logic                        flush;
    logic [TAG_W-1:0]            head;
    logic [TAG_W:0]              occupancy;
    logic                        full;
    logic                        empty;
    logic                        retire_err;
    logic [15:0]                 stall_cycles;
    modport master (output alloc_req, retire_cnt, flush,
                    input alloc_grant, alloc_tag, head, occupancy, full, empty, retire_err, stall_cycles);
    modport slave  (input alloc_req, retire_cnt, flush,
                    output alloc_grant, alloc_tag, head, occupancy, full, empty, retire_err, stall_cycles);
endinterface

// File: rtl/rob_tag_alloc.sv
// rob_tag_alloc: circular ROB tag allocator granting up to 4 tags and retiring up to 4 entries per cycle.
// Define ROB_ALLOC_STATS_EN to build the saturating stall_cycles counter; otherwise stall_cycles is 0.
module rob_tag_alloc #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    rob_tag_alloc_if.slave bus
);
    logic [TAG_W-1:0] head_q, tail_q, retire_ptr;
    logic [TAG_W:0]   occ_q, free;
    logic [2:0]       req, grant, eff;
    logic             err_q, over;
    // Grant depends only on registered occupancy, so same-cycle retirement never frees slots early.
    always_comb begin
        req        = bus.alloc_req > 3'd4 ? 3'd4 : bus.alloc_req;
        free       = (TAG_W+1)'(DEPTH) - occ_q;
        grant      = (rst || bus.flush) ? 3'd0 : ((TAG_W+1)'(req) > free ? free[2:0] : req);
        over       = (TAG_W+1)'(bus.retire_cnt) > occ_q;
        eff        = over ? occ_q[2:0] : bus.retire_cnt;
        retire_ptr = head_q + TAG_W'(eff);
    end
    for (genvar i = 0; i < 4; i++) begin : g_tag
        assign bus.alloc_tag[i] = tail_q + TAG_W'(i);
    end
    assign bus.alloc_grant = grant;
    assign bus.head        = head_q;
    assign bus.occupancy   = occ_q;
    assign bus.full        = occ_q == (TAG_W+1)'(DEPTH);
    assign bus.empty       = occ_q == '0;
    assign bus.retire_err  = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= retire_ptr;
            tail_q <= bus.flush ? retire_ptr : tail_q + TAG_W'(grant);
            occ_q  <= bus.flush ? '0 : occ_q + (TAG_W+1)'(grant) - (TAG_W+1)'(eff);
            err_q  <= err_q | over;
        end
    end
`ifdef ROB_ALLOC_STATS_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (!bus.flush && grant < req && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_rob_tag_alloc.sv
// tb_rob_tag_alloc: scenario tasks plus a reference model whose post-edge predictions are queued and
// compared after each clock edge.
module tb_rob_tag_alloc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_tag_alloc_if #(.TAG_W(4)) bus ();
    rob_tag_alloc #(.DEPTH(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int h; int t; int o; int err; int st; } exp_t;
    exp_t q[$];
    int checks = 0, fails = 0;
    int mh = 0, mt = 0, mo = 0, merr = 0, mst = 0;
    int last_grant;

    // One cycle: drive inputs, check combinational outputs, predict next state, clock, compare.
    task automatic step(input bit r, input int req, input int ret, input bit fl);
        int rq, g, er;
        exp_t e;
        rst = r;
        bus.alloc_req = 3'(req);
        bus.retire_cnt = 3'(ret);
        bus.flush = fl;
        #1;
        rq = req > 4 ? 4 : req;
        g = (r || fl) ? 0 : (rq < 16 - mo ? rq : 16 - mo);
        checks++;
        if (bus.alloc_grant !== 3'(g)) begin
            fails++;
            $display("FAIL grant: got %0d expected %0d (req=%0d occ=%0d)", bus.alloc_grant, g, req, mo);
        end
        last_grant = int'(bus.alloc_grant);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.alloc_tag[i] !== 4'((mt + i) % 16)) begin
                fails++;
                $display("FAIL tag%0d: got %0d expected %0d", i, bus.alloc_tag[i], (mt + i) % 16);
            end
        end
        er = ret > mo ? mo : ret;
        if (r) begin
            mh = 0; mt = 0; mo = 0; merr = 0; mst = 0;
        end else begin
            if (ret > mo) merr = 1;
`ifdef ROB_ALLOC_STATS_EN
            if (!fl && g < rq && mst < 65535) mst++;
`endif
            mh = (mh + er) % 16;
            if (fl) begin
                mt = mh; mo = 0;
            end else begin
                mt = (mt + g) % 16; mo = mo + g - er;
            end
        end
        e.h = mh; e.t = mt; e.o = mo; e.err = merr; e.st = mst;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (bus.head !== 4'(e.h) || bus.alloc_tag[0] !== 4'(e.t) || bus.occupancy !== 5'(e.o)) begin
            fails++;
            $display("FAIL state: head/tail/occ got %0d/%0d/%0d expected %0d/%0d/%0d",
                     bus.head, bus.alloc_tag[0], bus.occupancy, e.h, e.t, e.o);
        end
        checks++;
        if (bus.full !== (e.o == 16) || bus.empty !== (e.o == 0)) begin
            fails++;
            $display("FAIL flags: full/empty got %b/%b expected %b/%b", bus.full, bus.empty, e.o == 16, e.o == 0);
        end
        checks++;
        if (bus.retire_err !== 1'(e.err) || bus.stall_cycles !== 16'(e.st)) begin
            fails++;
            $display("FAIL err_stall: err/stall got %b/%0d expected %0d/%0d", bus.retire_err, bus.stall_cycles, e.err, e.st);
        end
    endtask

    task automatic test_reset();
        step(1, 4, 2, 1);
        checks++;
        if (last_grant !== 0) begin fails++; $display("FAIL reset_grant: got %0d expected 0", last_grant); end
        checks++;
        if (bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.head !== 4'd0 || bus.occupancy !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: full=%b empty=%b head=%0d occ=%0d expected 0/1/0/0", bus.full, bus.empty, bus.head, bus.occupancy);
        end
        checks++;
        if (bus.alloc_tag !== {4'd0, 4'd1, 4'd2, 4'd3}) begin
            fails++;
            $display("FAIL reset_tags: got %h expected 0123", bus.alloc_tag);
        end
    endtask

    task automatic test_fill();
        step(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.alloc_tag[0] !== 4'(4 * k)) begin
                fails++;
                $display("FAIL fill_tag: got %0d expected %0d", bus.alloc_tag[0], 4 * k);
            end
            step(0, 4, 0, 0);
            checks++;
            if (last_grant !== 4) begin fails++; $display("FAIL fill_grant: got %0d expected 4", last_grant); end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.occupancy !== 5'd16) begin
            fails++;
            $display("FAIL fill_full: full=%b occ=%0d expected 1/16", bus.full, bus.occupancy);
        end
    endtask

    task automatic test_stall();
        int exp_st;
        for (int k = 0; k < 5; k++) step(0, 2, 0, 0);
`ifdef ROB_ALLOC_STATS_EN
        exp_st = 5;
`else
        exp_st = 0;
`endif
        checks++;
        if (bus.stall_cycles !== 16'(exp_st)) begin
            fails++;
            $display("FAIL stall_count: got %0d expected %0d", bus.stall_cycles, exp_st);
        end
        step(1, 0, 0, 0);
        checks++;
        if (bus.stall_cycles !== 16'd0) begin fails++; $display("FAIL stall_reset: got %0d expected 0", bus.stall_cycles); end
    endtask

    task automatic test_simul_alloc_retire();
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 4, 0, 0);
        step(0, 2, 0, 0);
        step(0, 4, 4, 0);
        checks++;
        if (last_grant !== 2) begin fails++; $display("FAIL simul_grant: got %0d expected 2", last_grant); end
        checks++;
        if (bus.occupancy !== 5'd12 || bus.head !== 4'd4) begin
            fails++;
            $display("FAIL simul_state: occ=%0d head=%0d expected 12/4", bus.occupancy, bus.head);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 4, 0, 0);
        step(0, 2, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 4, 0);
        step(0, 0, 2, 0);
        rst = 0; bus.alloc_req = 3'd3; bus.retire_cnt = 3'd0; bus.flush = 0;
        #1;
        checks++;
        if (bus.alloc_tag[0] !== 4'd14 || bus.alloc_tag[1] !== 4'd15 || bus.alloc_tag[2] !== 4'd0) begin
            fails++;
            $display("FAIL wrap_tags: got %0d,%0d,%0d expected 14,15,0", bus.alloc_tag[0], bus.alloc_tag[1], bus.alloc_tag[2]);
        end
        step(0, 3, 0, 0);
        checks++;
        if (bus.alloc_tag[0] !== 4'd1 || bus.occupancy !== 5'd3) begin
            fails++;
            $display("FAIL wrap_state: tail=%0d occ=%0d expected 1/3", bus.alloc_tag[0], bus.occupancy);
        end
    endtask

    task automatic test_over_retire();
        step(1, 0, 0, 0);
        step(0, 2, 0, 0);
        step(0, 0, 4, 0);
        checks++;
        if (bus.occupancy !== 5'd0 || bus.head !== 4'd2 || bus.empty !== 1'b1 || bus.retire_err !== 1'b1) begin
            fails++;
            $display("FAIL over_retire: occ=%0d head=%0d empty=%b err=%b expected 0/2/1/1", bus.occupancy, bus.head, bus.empty, bus.retire_err);
        end
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        checks++;
        if (bus.retire_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", bus.retire_err); end
        step(1, 0, 0, 0);
        checks++;
        if (bus.retire_err !== 1'b0) begin fails++; $display("FAIL err_reset: got %b expected 0", bus.retire_err); end
    endtask

    task automatic test_flush();
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 4, 0, 0);
        step(0, 0, 3, 0);
        step(0, 4, 1, 1);
        checks++;
        if (last_grant !== 0) begin fails++; $display("FAIL flush_grant: got %0d expected 0", last_grant); end
        checks++;
        if (bus.occupancy !== 5'd0 || bus.head !== 4'd4 || bus.alloc_tag[0] !== 4'd4) begin
            fails++;
            $display("FAIL flush_state: occ=%0d head=%0d tail=%0d expected 0/4/4", bus.occupancy, bus.head, bus.alloc_tag[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 63) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                 $urandom_range(0, 15) == 0);
    endtask

    initial begin
        rst = 1; bus.alloc_req = 0; bus.retire_cnt = 0; bus.flush = 0;
        test_reset();
        test_fill();
        test_stall();
        test_simul_alloc_retire();
        test_wrap();
        test_over_retire();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
